// File: rtl/reg_op_sequencer_if.sv
// reg_op_sequencer_if: program-load, control and op-issue signals of the op sequencer
//   prog_we/prog_addr/prog_op : program memory write port (honoured in IDLE only)
//   prog_len/repeat_cnt/start : run length, extra passes, run request
//   stall/abort               : consumer back-pressure, immediate termination
//   op/op_valid/busy/done/pc/pass : issued op and sequencer status
//   master = sequencer side, slave = controller/consumer side
interface reg_op_sequencer_if #(
    parameter int OP_W  = 3,
    parameter int AW    = 3,
    parameter int CNT_W = 4
);
    logic            prog_we;
    logic [AW-1:0]   prog_addr;
    logic [OP_W-1:0] prog_op;
    logic [AW:0]     prog_len;
    logic            start;
    logic [CNT_W-1:0] repeat_cnt;
    logic            stall;
    logic            abort;
    logic [OP_W-1:0] op;
    logic            op_valid;
    logic            busy;
    logic            done;
    logic [AW-1:0]   pc;
    logic [CNT_W-1:0] pass;

    modport master (
        input  prog_we, prog_addr, prog_op, prog_len, start, repeat_cnt, stall, abort,
        output op, op_valid, busy, done, pc, pass
    );

    modport slave (
        output prog_we, prog_addr, prog_op, prog_len, start, repeat_cnt, stall, abort,
        input  op, op_valid, busy, done, pc, pass
    );
endinterface

// File: rtl/reg_op_sequencer.sv
// reg_op_sequencer: issues a stored program of register-bank op codes, one per accepted cycle
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears state and program memory
//   bus   : reg_op_sequencer_if.master (program load, start/stall/abort, op/op_valid/busy/done/pc/pass)
module reg_op_sequencer #(
    parameter int OP_W  = 3,
    parameter int DEPTH = 8,
    parameter int AW    = 3,
    parameter int CNT_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    reg_op_sequencer_if.master   bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q;
    logic [OP_W-1:0]  mem_q [DEPTH];
    logic [AW:0]      len_q;
    logic [CNT_W-1:0] reps_q;
    logic [AW-1:0]    pc_q;
    logic [CNT_W-1:0] pass_q;
    logic [OP_W-1:0]  op_q;
    logic             op_valid_q;
    logic             busy_q;
    logic             done_q;

    logic             accept;
    logic             last;
    logic [AW-1:0]    pc_d;
    logic [OP_W-1:0]  op0;

    always_comb begin
        accept = op_valid_q && !bus.stall && !bus.abort;
        last   = {1'b0, pc_q} == len_q - (AW+1)'(1);
        pc_d   = pc_q + AW'(1);
        // forward a same-cycle write to entry 0 so op matches mem[0] at run start
        op0    = (bus.prog_we && bus.prog_addr == '0) ? bus.prog_op : mem_q[0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            len_q      <= '0;
            reps_q     <= '0;
            pc_q       <= '0;
            pass_q     <= '0;
            op_q       <= '0;
            op_valid_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            if (state_q == IDLE && bus.prog_we) mem_q[bus.prog_addr] <= bus.prog_op;
            done_q <= 1'b0;
            if (bus.abort) begin
                state_q    <= IDLE;
                op_valid_q <= 1'b0;
                busy_q     <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (bus.start && bus.prog_len != '0) begin
                            state_q    <= RUN;
                            len_q      <= bus.prog_len > (AW+1)'(DEPTH) ? (AW+1)'(DEPTH) : bus.prog_len;
                            reps_q     <= bus.repeat_cnt;
                            pc_q       <= '0;
                            pass_q     <= '0;
                            op_q       <= op0;
                            op_valid_q <= 1'b1;
                            busy_q     <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (accept) begin
                            if (!last) begin
                                pc_q <= pc_d;
                                op_q <= mem_q[pc_d];
                            end else if (pass_q != reps_q) begin
                                pc_q   <= '0;
                                pass_q <= pass_q + CNT_W'(1);
                                op_q   <= mem_q[0];
                            end else begin
                                state_q    <= DONE;
                                op_valid_q <= 1'b0;
                                busy_q     <= 1'b0;
                                done_q     <= 1'b1;
                            end
                        end
                    end
                    DONE:    state_q <= IDLE;
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign bus.op       = op_q;
    assign bus.op_valid = op_valid_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.pc       = pc_q;
    assign bus.pass     = pass_q;
endmodule

// File: doc/reg_op_sequencer.md
Name: reg_op_sequencer

Overview:
- Upstream stage of the 8-entry register bank.
- Holds a small program of 3-bit register-bank op codes and issues one op per accepted cycle on `op`/`op_valid`.
- Supports multi-pass replay, back-pressure (`stall`) and abort.
- Replaces the hand-driven op sequence the bank bench applies today.

Parameters:
- OP_W, 3: op-code width; matches the bank's op input.
- DEPTH, 8: program memory entries; must be a power of two.
- AW, 3: program address width, log2(DEPTH).
- CNT_W, 4: width of the pass counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- prog_we  in  1  program write strobe.
- prog_addr  in  AW  program write address.
- prog_op  in  OP_W  op code written to prog_addr.
- prog_len  in  AW+1  number of program entries to issue, 0..DEPTH.
- start  in  1  begin issuing; sampled in IDLE only.
- repeat_cnt  in  CNT_W  extra passes; total passes = repeat_cnt+1.
- stall  in  1  consumer back-pressure; the op is not accepted this cycle.
- abort  in  1  terminate immediately.
- op  out  OP_W  op code to the register bank.
- op_valid  out  1  op is valid this cycle.
- busy  out  1  high in RUN.
- done  out  1  one-cycle pulse after the final op is accepted.
- pc  out  AW  index of the op currently presented.
- pass  out  CNT_W  current pass number, 0-based.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low, rst_n.
- While rst_n=0: all outputs 0, state IDLE, all program entries 0, latched length and repeat 0.
- Program memory is written on clk when prog_we=1 and state is IDLE. Writes in RUN or DONE are ignored.
- States:
  - IDLE: op_valid=0, busy=0.
  - RUN: busy=1.
  - DONE: lasts exactly one cycle. done=1, op_valid=0, busy=0.
- IDLE -> RUN: when start=1, abort=0 and prog_len!=0.
  - Latch len = min(prog_len, DEPTH) and reps = repeat_cnt.
  - pc=0, pass=0.
  - Next cycle: op_valid=1, op=mem[0].
  - Latency: start to first op_valid is 1 cycle.
- start=1 with prog_len=0: no state change, no done.
- start is ignored outside IDLE.
- In RUN, all outputs are registered, and op always equals mem[pc] of the latched program.
- Accept: a cycle with op_valid=1 and stall=0. The bank applies the op on that edge.
  - Not last entry (pc < len-1): pc <= pc+1.
  - Last entry, pass < reps: pc <= 0 and pass <= pass+1. Wrap is seamless; no bubble between passes.
  - Last entry, pass == reps: state <= DONE, op_valid <= 0.
- stall=1: op, pc, pass and op_valid hold.
- stall is don't-care outside RUN.
- DONE -> IDLE unconditionally. pc and pass keep their final values until the next start.
- A start asserted during the DONE cycle is ignored.
- abort=1 in any state: next cycle is IDLE with op_valid=0, busy=0, done=0.
  - abort has priority over start, stall and accept in the same cycle.
  - An op presented in the abort cycle is treated as not accepted, even if stall=0.
- Reset mid-RUN returns to the reset state immediately and clears the program memory.
- Counter widths: pass never exceeds reps. Overflow is impossible by construction.
- Throughput: 1 op per cycle without stall. Total accepts = len*(reps+1).

Test Plan:
1. Reset, then program mem[0..7] = 0..7, prog_len=8, repeat_cnt=0, start pulse, stall=0 -> op_valid high for exactly 8 cycles; op sequence 0,1,2,3,4,5,6,7 one per cycle; then done=1 for one cycle; then busy=0.
2. Program 3 ops {5,2,7}, repeat_cnt=2, start -> 9 accepts with op=5,2,7,5,2,7,5,2,7; pass steps 0->1->2 with no gap cycle; done pulses once after the 9th accept.
3. Same program as case 2 with stall high for 3 cycles while op=2 in pass 0 -> op holds 2 and pc=1 for those 3 cycles; total accepts still 9; done arrives 3 cycles later than in case 2.
4. Assert abort when pc=4 in a DEPTH=8 run -> op_valid=0 and busy=0 next cycle; done never pulses. Then start again -> issue restarts from op=mem[0], pass=0.
5. prog_we=1 to addr 0 with value 6 during RUN -> ignored; the current run and the next run both present the original mem[0]. Separately, start with prog_len=0 -> stays IDLE, no done.
6. Drive rst_n low asynchronously mid-RUN between clock edges -> outputs go to 0 without waiting for clk. After release, a run with prog_len=2 issues op=0,0 because memory was cleared.
